nx_instr_ram_arbiter: RTL
=========================

Name: nx_instr_ram_arbiter

Overview:
- Shares one single-port instruction RAM per node between two requesters: the core's instruction fetch (reads) and the message-driven instruction loader (writes).
- Generates the fetch-side read data and stall.
- Tracks the populated instruction count that the core uses as its end-of-program bound.
- Sits between the node's RAM macro, the loader and the core, inside the node wrapper.

Parameters:
- RAM_ADDR_W, 10, instruction RAM address width.
- RAM_DATA_W, 32, instruction RAM data width.
- MAX_STARVE, 4, maximum number of consecutive cycles the core may lose arbitration before it is forced a grant (≥1).

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_core_addr  input  RAM_ADDR_W  fetch address
- i_core_rd_en  input  1  fetch request
- o_core_rd_data  output  RAM_DATA_W  fetched instruction, valid the cycle after grant
- o_core_stall  output  1  high when o_core_rd_data does not hold the previously requested word
- i_load_addr  input  RAM_ADDR_W  write address
- i_load_data  input  RAM_DATA_W  write data
- i_load_valid  input  1  write request
- o_load_ready  output  1  write accepted this cycle
- i_clear  input  1  reset populated count (program reload)
- o_populated  output  NODE_PARAM_WIDTH  highest written address + 1
- o_ram_addr  output  RAM_ADDR_W  RAM address
- o_ram_wr_data  output  RAM_DATA_W  RAM write data
- o_ram_wr_en  output  1  RAM write strobe
- o_ram_rd_en  output  1  RAM read strobe
- i_ram_rd_data  input  RAM_DATA_W  RAM read data, one-cycle latency

Behaviour:
- One clock i_clk; reset i_rst is synchronous and active-high.
- Reset values:
  - starve counter = 0, core_req_q = 0, core_gnt_q = 0, o_populated = 0.
  - All RAM strobes and o_load_ready low.
  - o_core_stall low.
  - o_core_rd_data passes i_ram_rd_data through; its value is don't-care while stalled.
- Arbitration is combinational each cycle:
  - Only one requester → it is granted.
  - Both requesting → loader wins unless starve counter == MAX_STARVE, in which case the core wins.
  - Neither requesting → RAM idle: all strobes low, o_ram_addr holds its last value.
- Starve counter:
  - Increments (saturating at MAX_STARVE) on each cycle the core requests and is not granted.
  - Clears on a core grant or on any cycle without a core request.
- Core grant: o_ram_rd_en = 1, o_ram_addr = i_core_addr.
- Loader grant: o_ram_wr_en = 1, o_ram_addr = i_load_addr, o_ram_wr_data = i_load_data, o_load_ready = 1.
- o_load_ready is never high unless i_load_valid is high. The loader holds addr/data stable until ready.
- Read pipeline:
  - core_req_q <= i_core_rd_en; core_gnt_q <= core grant.
  - o_core_stall = core_req_q && !core_gnt_q (registered, no combinational path from inputs).
  - A stalled fetch is re-presented by the core at the same address. The arbiter keeps no per-address state.
- Populated tracking:
  - On an accepted write, o_populated <= max(o_populated, zero-extended i_load_addr + 1).
  - i_clear has priority over a same-cycle write: o_populated <= 0 and the write still goes to RAM.
- Width rule: NODE_PARAM_WIDTH must be > RAM_ADDR_W, so that address 2^RAM_ADDR_W−1 yields 2^RAM_ADDR_W without wrap. Check this with an elaboration-time assertion.
- Reset mid-operation:
  - All pending state is dropped.
  - A grant in the reset cycle is suppressed: no RAM strobe while i_rst is high.
  - o_core_stall is low in the cycle after reset.
- Write-after-read to the same address in consecutive cycles needs no special handling. A read returns the old data if it was granted before the write.

Decomposition:
- NODE_PARAM_WIDTH comes from NXConstants; no new package types are needed.
- Add a shared arb_owner_t enum {ARB_NONE, ARB_CORE, ARB_LOAD} to NXConstants for reuse by future node-level arbiters.
- One natural sub-module, nx_starve_counter: saturating counter with increment/clear/limit flag. Everything else is inline.

Test Plan:
- Core only: rd_en at addrs 0,1,2 on consecutive cycles, RAM preloaded 0xA,0xB,0xC → rd_data 0xA,0xB,0xC on cycles 1–3, stall never high.
- Loader only: writes to addr 5 then 2 → two RAM writes, load_ready high both cycles, o_populated 6 then stays 6.
- Contention with MAX_STARVE=4: continuous load_valid and core rd_en → loader granted 4 cycles, core on 5th, pattern repeats; stall high exactly 4 of every 5 read-return cycles.
- Boundary: write addr 1023 with RAM_ADDR_W=10 → o_populated = 1024. Same-cycle i_clear + write addr 3 → o_populated = 0 and RAM written.
- Reset mid-contention: assert i_rst while both request → no strobes that cycle, stall low next cycle, starve counter restarts from 0 (core wins after 4 more losses).
- Idle: no requests for 10 cycles → wr_en/rd_en/load_ready/stall all low, o_populated unchanged.

Source files
------------

// File: rtl/nx_instr_ram_arbiter_pkg.sv
// Node-level constants and shared types for the instruction RAM arbiter and
// future node-level arbiters.
package nx_instr_ram_arbiter_pkg;

  // Wide enough to hold 2^RAM_ADDR_W for the populated instruction count.
  localparam int unsigned NODE_PARAM_WIDTH = 16;

  typedef enum logic [1:0] {
    ARB_NONE,
    ARB_CORE,
    ARB_LOAD
  } arb_owner_t;

endpackage

// File: rtl/nx_starve_counter.sv
// Saturating counter of consecutive lost arbitrations, with a limit flag.
module nx_starve_counter
  import nx_instr_ram_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam int unsigned CntW = $clog2(LIMIT + 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  assign o_at_limit = (cnt_q == CntW'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && !o_at_limit) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nx_instr_ram_arbiter.sv
// Shares the node's single-port instruction RAM between core fetch (reads) and
// the instruction loader (writes); tracks the populated instruction count.
module nx_instr_ram_arbiter
  import nx_instr_ram_arbiter_pkg::*;
#(
  parameter int unsigned RAM_ADDR_W = 10,
  parameter int unsigned RAM_DATA_W = 32,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [RAM_ADDR_W-1:0]       i_core_addr,
  input  logic                        i_core_rd_en,
  output logic [RAM_DATA_W-1:0]       o_core_rd_data,
  output logic                        o_core_stall,
  input  logic [RAM_ADDR_W-1:0]       i_load_addr,
  input  logic [RAM_DATA_W-1:0]       i_load_data,
  input  logic                        i_load_valid,
  output logic                        o_load_ready,
  input  logic                        i_clear,
  output logic [NODE_PARAM_WIDTH-1:0] o_populated,
  output logic [RAM_ADDR_W-1:0]       o_ram_addr,
  output logic [RAM_DATA_W-1:0]       o_ram_wr_data,
  output logic                        o_ram_wr_en,
  output logic                        o_ram_rd_en,
  input  logic [RAM_DATA_W-1:0]       i_ram_rd_data
);

  if (NODE_PARAM_WIDTH <= RAM_ADDR_W) begin : gen_bad_width
    $error("NODE_PARAM_WIDTH must exceed RAM_ADDR_W");
  end
  if (MAX_STARVE < 1) begin : gen_bad_starve
    $error("MAX_STARVE must be at least 1");
  end

  arb_owner_t owner;
  logic       core_gnt, load_gnt, starve_limit;

  logic                        core_req_d, core_req_q;
  logic                        core_gnt_d, core_gnt_q;
  logic [NODE_PARAM_WIDTH-1:0] populated_d, populated_q;
  logic [NODE_PARAM_WIDTH-1:0] load_end;
  logic [RAM_ADDR_W-1:0]       ram_addr_d, ram_addr_q;

  // Reset suppresses any grant so no RAM strobe fires in a reset cycle.
  always_comb begin
    owner = ARB_NONE;
    if (!i_rst) begin
      if (i_core_rd_en && (!i_load_valid || starve_limit)) begin
        owner = ARB_CORE;
      end else if (i_load_valid) begin
        owner = ARB_LOAD;
      end
    end
  end

  assign core_gnt = (owner == ARB_CORE);
  assign load_gnt = (owner == ARB_LOAD);

  nx_starve_counter #(
    .LIMIT (MAX_STARVE)
  ) u_starve (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_inc      (i_core_rd_en && !core_gnt),
    .i_clr      (!i_core_rd_en || core_gnt),
    .o_at_limit (starve_limit)
  );

  always_comb begin
    ram_addr_d = ram_addr_q;
    unique case (owner)
      ARB_CORE: ram_addr_d = i_core_addr;
      ARB_LOAD: ram_addr_d = i_load_addr;
      default:  ram_addr_d = ram_addr_q;
    endcase
  end

  assign o_ram_addr     = ram_addr_d;
  assign o_ram_wr_data  = i_load_data;
  assign o_ram_wr_en    = load_gnt;
  assign o_ram_rd_en    = core_gnt;
  assign o_load_ready   = load_gnt;
  assign o_core_rd_data = i_ram_rd_data;
  assign o_core_stall   = core_req_q && !core_gnt_q;
  assign o_populated    = populated_q;

  assign load_end = NODE_PARAM_WIDTH'(i_load_addr) + NODE_PARAM_WIDTH'(1);

  // Clear wins over a same-cycle write; the write itself still reaches RAM.
  always_comb begin
    core_req_d  = i_core_rd_en;
    core_gnt_d  = core_gnt;
    populated_d = populated_q;
    if (i_clear) begin
      populated_d = '0;
    end else if (load_gnt && (load_end > populated_q)) begin
      populated_d = load_end;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      core_req_q  <= 1'b0;
      core_gnt_q  <= 1'b0;
      populated_q <= '0;
      ram_addr_q  <= '0;
    end else begin
      core_req_q  <= core_req_d;
      core_gnt_q  <= core_gnt_d;
      populated_q <= populated_d;
      ram_addr_q  <= ram_addr_d;
    end
  end

endmodule
